// File: rtl/color_word_generator.sv
// Emits the ASCII word "COLOR" or "COLOUR" as a valid/ready letter stream,
// repeated a programmable number of times with an idle gap between words.
module color_word_generator #(
    parameter int REPEAT_W = 4,
    parameter int GAP_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                variant,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0]    gap,
    input  logic                abort,
    input  logic                ready,
    output logic [7:0]          letter,
    output logic                valid,
    output logic                word_end,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam logic [7:0] CH_C = 8'h43;
    localparam logic [7:0] CH_O = 8'h4F;
    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_U = 8'h55;
    localparam logic [7:0] CH_R = 8'h52;

    state_t              state, state_next;
    logic [2:0]          idx, idx_next;
    logic [REPEAT_W-1:0] words_left, words_next;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_next;
    logic [GAP_W-1:0]    gap_len, gap_len_next;
    logic                variant_q, variant_next;
    logic [7:0]          letter_next;
    logic                valid_next, word_end_next, busy_next, done_next;
    logic                transfer;

    function automatic logic [2:0] last_idx(input logic v);
        return v ? 3'd5 : 3'd4;
    endfunction

    // Index 4 is 'U' only in COLOUR; otherwise it is the closing 'R'.
    function automatic logic [7:0] letter_code(input logic v, input logic [2:0] i);
        logic [7:0] code;
        code = CH_R;
        case (i)
            3'd0:    code = CH_C;
            3'd1:    code = CH_O;
            3'd2:    code = CH_L;
            3'd3:    code = CH_O;
            3'd4:    code = v ? CH_U : CH_R;
            default: code = CH_R;
        endcase
        return code;
    endfunction

    assign transfer = valid && ready;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        words_next   = words_left;
        gap_cnt_next = gap_cnt;
        gap_len_next = gap_len;
        variant_next = variant_q;
        done_next    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start && repeat_cnt != '0) begin
                    variant_next = variant;
                    gap_len_next = gap;
                    words_next   = repeat_cnt;
                    idx_next     = 3'd0;
                    state_next   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (transfer) begin
                    if (word_end) begin
                        words_next = words_left - 1'b1;
                        idx_next   = 3'd0;
                        if (words_left == REPEAT_W'(1)) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else if (gap_len != '0) begin
                            state_next   = ST_GAP;
                            gap_cnt_next = gap_len;
                        end
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_next = ST_SEND;
                    idx_next   = 3'd0;
                end else begin
                    gap_cnt_next = gap_cnt - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort wins over everything, including the final done pulse.
        if (abort && state != ST_IDLE) begin
            state_next = ST_IDLE;
            done_next  = 1'b0;
        end

        // Outputs are derived from the next state so they can be registered.
        valid_next    = (state_next == ST_SEND);
        letter_next   = valid_next ? letter_code(variant_next, idx_next) : 8'h00;
        word_end_next = valid_next && (idx_next == last_idx(variant_next));
        busy_next     = (state_next != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            words_left <= '0;
            gap_cnt    <= '0;
            gap_len    <= '0;
            variant_q  <= 1'b0;
            letter     <= 8'h00;
            valid      <= 1'b0;
            word_end   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            words_left <= words_next;
            gap_cnt    <= gap_cnt_next;
            gap_len    <= gap_len_next;
            variant_q  <= variant_next;
            letter     <= letter_next;
            valid      <= valid_next;
            word_end   <= word_end_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

endmodule
